frame_commit_ctrl: RTL and testbench

- Schedules game-state updates into the picture processing unit so that offsets and static-tile attributes change only at frame boundaries, never mid-scan.
- Sits between the game statemachine and the ppu.
- Stages one pending update from the statemachine and commits it atomically after the vsync edge.
- Emits the ppu `update` strobe and a per-frame `frame_tick` that paces the statemachine.

---
 rtl/console_pkg.sv | 15 +
 rtl/shadow_stage.sv | 43 ++++
 rtl/frame_commit_ctrl.sv | 142 ++++++++++++++
 tb/tb_frame_commit_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/console_pkg.sv
// Constants and types shared by the ppu, the game statemachine and the
// frame commit controller.
package console_pkg;

  localparam int OFFSET_W = 12;
  localparam int STATIC_W = 132;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    COMMIT = 2'd2,
    TICK   = 2'd3
  } fsm_state_t;

endpackage

// File: rtl/shadow_stage.sv
// Single-entry shadow buffer between the statemachine and the commit FSM:
// accepts one update when empty, acknowledges it, and empties on commit.
module shadow_stage #(
  parameter int OFFSET_W = console_pkg::OFFSET_W,
  parameter int STATIC_W = console_pkg::STATIC_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req,
  input  logic [OFFSET_W-1:0] in_offset_x,
  input  logic [OFFSET_W-1:0] in_offset_y,
  input  logic [STATIC_W-1:0] in_statics,
  input  logic                clear,
  output logic                pend,
  output logic                ack,
  output logic [OFFSET_W-1:0] shadow_x,
  output logic [OFFSET_W-1:0] shadow_y,
  output logic [STATIC_W-1:0] shadow_statics
);

  // Clear only fires while pend is set, so it can never race a new latch.
  always_ff @(posedge clock) begin
    if (reset) begin
      pend           <= 1'b0;
      ack            <= 1'b0;
      shadow_x       <= '0;
      shadow_y       <= '0;
      shadow_statics <= '0;
    end else begin
      ack <= 1'b0;
      if (clear) begin
        pend <= 1'b0;
      end else if (req && !pend) begin
        pend           <= 1'b1;
        ack            <= 1'b1;
        shadow_x       <= in_offset_x;
        shadow_y       <= in_offset_y;
        shadow_statics <= in_statics;
      end
    end
  end

endmodule

// File: rtl/frame_commit_ctrl.sv
// Commits staged scroll offsets and static attributes to the ppu only at
// frame boundaries, and paces the statemachine with one tick per frame.
module frame_commit_ctrl #(
  parameter int OFFSET_W     = console_pkg::OFFSET_W,
  parameter int STATIC_W     = console_pkg::STATIC_W,
  parameter int FCNT_W       = 16,
  parameter int COMMIT_DELAY = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                vsync,
  input  logic                sm_req,
  input  logic [OFFSET_W-1:0] sm_offset_x,
  input  logic [OFFSET_W-1:0] sm_offset_y,
  input  logic [STATIC_W-1:0] sm_statics,
  output logic                sm_ack,
  output logic [OFFSET_W-1:0] offset_x,
  output logic [OFFSET_W-1:0] offset_y,
  output logic [STATIC_W-1:0] statics,
  output logic                update,
  output logic                frame_tick,
  output logic [FCNT_W-1:0]   frame_count,
  output logic [FCNT_W-1:0]   missed_count,
  output logic                overrun
);
  import console_pkg::*;

  localparam int CNT_W = (COMMIT_DELAY > 1) ? $clog2(COMMIT_DELAY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((COMMIT_DELAY > 0) ? COMMIT_DELAY - 1 : 0);

  fsm_state_t          state;
  fsm_state_t          state_next;
  logic                vsync_d;
  logic                frame_edge;
  logic                pend;
  logic                pend_at_edge;
  logic                commit_pend;
  logic                clear;
  logic [CNT_W-1:0]    cnt;
  logic [OFFSET_W-1:0] shadow_x;
  logic [OFFSET_W-1:0] shadow_y;
  logic [STATIC_W-1:0] shadow_statics;

  shadow_stage #(
    .OFFSET_W (OFFSET_W),
    .STATIC_W (STATIC_W)
  ) u_shadow (
    .clock          (clock),
    .reset          (reset),
    .req            (sm_req),
    .in_offset_x    (sm_offset_x),
    .in_offset_y    (sm_offset_y),
    .in_statics     (sm_statics),
    .clear          (clear),
    .pend           (pend),
    .ack            (sm_ack),
    .shadow_x       (shadow_x),
    .shadow_y       (shadow_y),
    .shadow_statics (shadow_statics)
  );

  assign frame_edge  = vsync_d & ~vsync;
  // With zero delay the commit is decided in the edge cycle, before pend_at_edge loads.
  assign commit_pend = (state == IDLE) ? pend : pend_at_edge;
  assign clear       = (state == COMMIT) && pend_at_edge;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (frame_edge) begin
          state_next = (COMMIT_DELAY == 0) ? COMMIT : DELAY;
        end else begin
          state_next = IDLE;
        end
      end
      DELAY: begin
        if (cnt == CNT_LAST) begin
          state_next = COMMIT;
        end else begin
          state_next = DELAY;
        end
      end
      COMMIT:  state_next = TICK;
      TICK:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      vsync_d      <= 1'b1;
      pend_at_edge <= 1'b0;
      cnt          <= '0;
    end else begin
      state   <= state_next;
      vsync_d <= vsync;
      if ((state == IDLE) && frame_edge) begin
        pend_at_edge <= pend;
      end
      cnt <= (state == DELAY) ? cnt + CNT_W'(1) : '0;
    end
  end

  // Outputs load on entry to COMMIT/TICK so the pulses are visible during those states.
  always_ff @(posedge clock) begin
    if (reset) begin
      offset_x     <= '0;
      offset_y     <= '0;
      statics      <= '0;
      update       <= 1'b0;
      overrun      <= 1'b0;
      frame_tick   <= 1'b0;
      frame_count  <= '0;
      missed_count <= '0;
    end else begin
      update     <= 1'b0;
      overrun    <= 1'b0;
      frame_tick <= 1'b0;
      if (state_next == COMMIT) begin
        if (commit_pend) begin
          update   <= 1'b1;
          offset_x <= shadow_x;
          offset_y <= shadow_y;
          statics  <= shadow_statics;
        end else begin
          overrun <= 1'b1;
          if (missed_count != {FCNT_W{1'b1}}) begin
            missed_count <= missed_count + FCNT_W'(1);
          end
        end
      end
      if (state_next == TICK) begin
        frame_tick  <= 1'b1;
        frame_count <= frame_count + FCNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_frame_commit_ctrl.sv
// Scoreboard bench: two controllers (commit delay 4 / 16-bit counters and
// commit delay 0 / 8-bit counters) share vsync and reset.
module tb_frame_commit_ctrl;

  typedef struct {
    int          obs;
    logic        upd;
    logic [11:0] ox;
    logic [11:0] oy;
    logic [131:0] st;
    logic [15:0] cnt;
  } exp_t;

  typedef struct {
    logic [11:0]  ox;
    logic [11:0]  oy;
    logic [131:0] st;
  } req_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic         reset = 1'b1;
  logic         vsync = 1'b1;
  logic         req [2];
  logic [11:0]  ix [2];
  logic [11:0]  iy [2];
  logic [131:0] ist [2];

  logic         a0, u0, v0, t0, a1, u1, v1, t1;
  logic [11:0]  x0, y0, x1, y1;
  logic [131:0] s0, s1;
  logic [15:0]  f0, m0;
  logic [7:0]   f1, m1;

  frame_commit_ctrl #(.FCNT_W(16), .COMMIT_DELAY(4)) dut0 (
    .clock(clock), .reset(reset), .vsync(vsync), .sm_req(req[0]),
    .sm_offset_x(ix[0]), .sm_offset_y(iy[0]), .sm_statics(ist[0]),
    .sm_ack(a0), .offset_x(x0), .offset_y(y0), .statics(s0), .update(u0),
    .frame_tick(t0), .frame_count(f0), .missed_count(m0), .overrun(v0));

  frame_commit_ctrl #(.FCNT_W(8), .COMMIT_DELAY(0)) dut1 (
    .clock(clock), .reset(reset), .vsync(vsync), .sm_req(req[1]),
    .sm_offset_x(ix[1]), .sm_offset_y(iy[1]), .sm_statics(ist[1]),
    .sm_ack(a1), .offset_x(x1), .offset_y(y1), .statics(s1), .update(u1),
    .frame_tick(t1), .frame_count(f1), .missed_count(m1), .overrun(v1));

  int vectors = 0;
  int miscompares = 0;
  int pc = 0;

  exp_t ack_q [2][$];
  exp_t com_q [2][$];
  exp_t tck_q [2][$];
  req_t want_q [2][$];

  // Reference model: per-frame rules expressed as cycle windows.
  int           dly [2] = '{4, 0};
  int           fmask [2] = '{32'h0000_FFFF, 32'h0000_00FF};
  logic         m_pend [2];
  logic [11:0]  m_sx [2];
  logic [11:0]  m_sy [2];
  logic [131:0] m_sst [2];
  logic [11:0]  m_ox [2];
  logic [11:0]  m_oy [2];
  logic [131:0] m_ost [2];
  int           m_missed [2];
  int           m_frames [2];
  int           m_free [2];
  int           m_clear_at [2];
  logic         latched [2];
  logic         m_prev_v = 1'b1;

  always @(posedge clock) pc <= pc + 1;

  task automatic cmp(input string name, input int i, input logic [131:0] act, input logic [131:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d obs %0d: got %h expected %h", name, i, pc, act, exp);
    end
  endtask

  task automatic chk(input int i, input logic ack, input logic upd, input logic ovr, input logic tck,
                     input logic [11:0] ox, input logic [11:0] oy, input logic [131:0] st,
                     input logic [15:0] fc, input logic [15:0] mc);
    exp_t e;
    if (ack_q[i].size() > 0 && ack_q[i][0].obs == pc) begin
      void'(ack_q[i].pop_front());
      cmp("sm_ack", i, 132'(ack), 132'(1'b1));
    end else begin
      cmp("sm_ack_idle", i, 132'(ack), 132'(1'b0));
    end
    if (com_q[i].size() > 0 && com_q[i][0].obs == pc) begin
      e = com_q[i].pop_front();
      cmp("update", i, 132'(upd), 132'(e.upd));
      cmp("overrun", i, 132'(ovr), 132'(!e.upd));
      cmp("offset_x", i, 132'(ox), 132'(e.ox));
      cmp("offset_y", i, 132'(oy), 132'(e.oy));
      cmp("statics", i, st, e.st);
      cmp("missed_count", i, 132'(mc), 132'(e.cnt));
    end else begin
      cmp("update_idle", i, 132'(upd), 132'(1'b0));
      cmp("overrun_idle", i, 132'(ovr), 132'(1'b0));
    end
    if (tck_q[i].size() > 0 && tck_q[i][0].obs == pc) begin
      e = tck_q[i].pop_front();
      cmp("frame_tick", i, 132'(tck), 132'(1'b1));
      cmp("frame_count", i, 132'(fc), 132'(e.cnt));
    end else begin
      cmp("frame_tick_idle", i, 132'(tck), 132'(1'b0));
    end
  endtask

  always @(negedge clock) begin
    chk(0, a0, u0, v0, t0, x0, y0, s0, f0, m0);
    chk(1, a1, u1, v1, t1, x1, y1, s1, {8'h00, f1}, {8'h00, m1});
  end

  task automatic model(input int i, input int n);
    exp_t e;
    logic old_pend;
    if (reset) begin
      ack_q[i].delete(); com_q[i].delete(); tck_q[i].delete();
      m_pend[i] = 1'b0; m_sx[i] = '0; m_sy[i] = '0; m_sst[i] = '0;
      m_ox[i] = '0; m_oy[i] = '0; m_ost[i] = '0;
      m_missed[i] = 0; m_frames[i] = 0; m_free[i] = 0; m_clear_at[i] = -1;
      return;
    end
    old_pend = m_pend[i];
    if (n >= m_free[i] && m_prev_v && !vsync) begin
      if (old_pend) begin
        m_ox[i] = m_sx[i]; m_oy[i] = m_sy[i]; m_ost[i] = m_sst[i];
      end else if (m_missed[i] < fmask[i]) begin
        m_missed[i]++;
      end
      e.obs = n + dly[i]; e.upd = old_pend;
      e.ox = m_ox[i]; e.oy = m_oy[i]; e.st = m_ost[i]; e.cnt = 16'(m_missed[i]);
      com_q[i].push_back(e);
      m_frames[i] = (m_frames[i] + 1) & fmask[i];
      e.obs = n + dly[i] + 1; e.cnt = 16'(m_frames[i]);
      tck_q[i].push_back(e);
      m_clear_at[i] = old_pend ? n + dly[i] + 1 : -1;
      m_free[i] = n + dly[i] + 3;
    end
    if (n == m_clear_at[i]) begin
      m_pend[i] = 1'b0;
    end else if (req[i] && !old_pend) begin
      m_pend[i] = 1'b1;
      m_sx[i] = ix[i]; m_sy[i] = iy[i]; m_sst[i] = ist[i];
      latched[i] = 1'b1;
      e.obs = n;
      ack_q[i].push_back(e);
    end
  endtask

  task automatic step(input logic v, input logic r);
    req_t d;
    logic [159:0] rnd;
    @(negedge clock);
    #1;
    vsync = v;
    reset = r;
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        req[i] = 1'b0;
        want_q[i].delete();
      end else if (latched[i]) begin
        req[i] = 1'b0;
      end else if (!req[i] && want_q[i].size() > 0) begin
        d = want_q[i].pop_front();
        req[i] = 1'b1; ix[i] = d.ox; iy[i] = d.oy; ist[i] = d.st;
      end
      if (!req[i]) begin
        rnd = {$urandom, $urandom, $urandom, $urandom, $urandom};
        ix[i] = rnd[11:0]; iy[i] = rnd[23:12]; ist[i] = rnd[131:0];
      end
      latched[i] = 1'b0;
      model(i, pc + 1);
    end
    m_prev_v = r ? 1'b1 : v;
  endtask

  task automatic frame(input int lo, input int hi);
    repeat (lo) step(1'b0, 1'b0);
    repeat (hi) step(1'b1, 1'b0);
  endtask

  task automatic want_both(input logic [11:0] ox, input logic [11:0] oy, input logic [131:0] st);
    req_t d;
    d.ox = ox; d.oy = oy; d.st = st;
    want_q[0].push_back(d);
    want_q[1].push_back(d);
  endtask

  task automatic want_rand(input int i);
    req_t d;
    logic [159:0] rnd;
    rnd = {$urandom, $urandom, $urandom, $urandom, $urandom};
    d.ox = rnd[11:0]; d.oy = rnd[27:16]; d.st = rnd[159:28];
    want_q[i].push_back(d);
  endtask

  initial begin
    logic [131:0] ones;
    ones = '1;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; ix[i] = '0; iy[i] = '0; ist[i] = '0; latched[i] = 1'b0;
      m_pend[i] = 1'b0; m_free[i] = 0; m_clear_at[i] = -1;
    end
    repeat (3) step(1'b1, 1'b1);
    repeat (4) step(1'b1, 1'b0);
    // Empty frame: overrun only.
    frame(3, 10);
    // Staged data committed at the next edge.
    want_both(12'h123, 12'h045, ones);
    repeat (10) step(1'b1, 1'b0);
    frame(3, 10);
    // Request arriving in the edge cycle waits one frame.
    want_both(12'h010, 12'h000, '0);
    frame(3, 10);
    frame(3, 10);
    // Back-to-back requests: second is held until the first commits.
    want_both(12'hAAA, 12'h555, {33{4'hA}});
    want_both(12'hBBB, 12'h666, {33{4'h5}});
    repeat (4) step(1'b1, 1'b0);
    frame(3, 12);
    frame(3, 12);
    // Reset in the middle of the commit delay with data pending.
    want_both(12'hFED, 12'hCBA, {33{4'h7}});
    repeat (3) step(1'b1, 1'b0);
    frame(2, 0);
    repeat (2) step(1'b1, 1'b1);
    repeat (3) step(1'b1, 1'b0);
    frame(3, 10);
    // Random frame lengths, including ones too short for the delayed instance.
    for (int f = 0; f < 400; f++) begin
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 2) != 0) want_rand(i);
      end
      frame($urandom_range(1, 3), $urandom_range(1, 12));
    end
    // Enough short frames to wrap the 8-bit frame counter.
    for (int f = 0; f < 300; f++) begin
      if ($urandom_range(0, 1) != 0) want_rand(1);
      frame(2, 2);
    end
    repeat (10) step(1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      cmp("ack_q_drained", i, 132'(ack_q[i].size()), 132'(0));
      cmp("com_q_drained", i, 132'(com_q[i].size()), 132'(0));
      cmp("tck_q_drained", i, 132'(tck_q[i].size()), 132'(0));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
